// File: rtl/multiplex_regbank_pkg.sv
// Shared definitions for the general-purpose register bank and the flat-bus
// selectors built on the same packing.
//   DEF_WIDTH/DEF_DEPTH/DEF_SEL_W : default bank geometry
//   ZERO_IDX                      : index of the optionally hardwired-zero entry
//   field_base()                  : LSB position of entry idx inside a flat bus
//                                   where entry 0 sits in the MSBs
package multiplex_regbank_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_SEL_W = 5;
    localparam int ZERO_IDX  = 0;

    function automatic int field_base(input int idx, input int depth, input int width);
        return (depth - idx - 1) * width;
    endfunction

endpackage

// File: rtl/multiplex_sel.sv
// Combinational WIDTH x DEPTH selector over a flat bus (entry 0 in the MSBs).
//   flat : packed entries, WIDTH*DEPTH bits
//   sel  : entry select, unsigned SEL_W bits
//   dout : selected entry, or 0 when sel >= DEPTH
module multiplex_sel
    import multiplex_regbank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [WIDTH*DEPTH-1:0] flat,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       dout
);

    logic [WIDTH-1:0] ent [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
        assign ent[g] = flat[field_base(g, DEPTH, WIDTH) +: WIDTH];
    end

    // Codes at or above DEPTH never match, so they fall through to zero.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == SEL_W'(i)) begin
                dout = ent[i];
            end
        end
    end

endmodule

// File: rtl/multiplex_regbank.sv
// General-purpose register store feeding the ALU operand selectors.
// Two registered read ports with write-first bypass, one write port, and a
// continuous flat snapshot of every entry.
//   clk, rst         : clock, asynchronous active-high reset
//   we/waddr/wdata   : write port (ignored out of range or to a hardwired entry 0)
//   ren              : read request for both ports
//   raddr_a/raddr_b  : read addresses
//   rd_a/rd_b        : read data, loaded on the edge where ren=1
//   rvalid           : high for the cycle after a read request
//   flat_q           : all entries, entry 0 in the MSBs
module multiplex_regbank
    import multiplex_regbank_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int ZERO_REG0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [SEL_W-1:0]       waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   ren,
    input  logic [SEL_W-1:0]       raddr_a,
    input  logic [SEL_W-1:0]       raddr_b,
    output logic [WIDTH-1:0]       rd_a,
    output logic [WIDTH-1:0]       rd_b,
    output logic                   rvalid,
    output logic [WIDTH*DEPTH-1:0] flat_q
);

    if (DEPTH > (1 << SEL_W) || DEPTH < 2) begin : g_bad_depth
        $error("multiplex_regbank: DEPTH must lie in 2..2**SEL_W");
    end

    localparam logic [SEL_W:0] DEPTH_L = (SEL_W + 1)'(DEPTH);
    localparam bit             HARD0   = (ZERO_REG0 != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] next_a, next_b;

    // A write that will actually land; also the only condition that may bypass.
    assign wr_ok = we && ({1'b0, waddr} < DEPTH_L)
                      && !(HARD0 && (waddr == SEL_W'(ZERO_IDX)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (waddr == SEL_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign flat_q[field_base(g, DEPTH, WIDTH) +: WIDTH] =
            (HARD0 && (g == ZERO_IDX)) ? '0 : mem[g];
    end

    // Selecting from flat_q gives the hardwired-zero entry for free.
    multiplex_sel #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel_a (
        .flat (flat_q),
        .sel  (raddr_a),
        .dout (sel_a)
    );

    multiplex_sel #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel_b (
        .flat (flat_q),
        .sel  (raddr_b),
        .dout (sel_b)
    );

    assign next_a = (wr_ok && (raddr_a == waddr)) ? wdata : sel_a;
    assign next_b = (wr_ok && (raddr_b == waddr)) ? wdata : sel_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a   <= '0;
            rd_b   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) begin
                rd_a <= next_a;
                rd_b <= next_b;
            end
        end
    end

endmodule

// File: doc/multiplex_regbank.md
Name: multiplex_regbank

Overview:
Parametrised register bank with two registered read ports, one write port and a flat snapshot output. It succeeds the fixed 16x32 combinational selectors. It holds its own storage, so depth, width and select width are configurable. It adds write-first bypass, out-of-range handling and a hardwired-zero entry option. It sits in the datapath as the general-purpose register store feeding the ALU operand selectors.

Parameters:
WIDTH, 32, bits per entry
DEPTH, 16, number of entries (2..2**SEL_W)
SEL_W, 5, address/select width
ZERO_REG0, 1, when 1 entry 0 is hardwired to zero

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
we  input  1  write enable
waddr  input  SEL_W  write address
wdata  input  WIDTH  write data
ren  input  1  read request for both ports
raddr_a  input  SEL_W  read address port A
raddr_b  input  SEL_W  read address port B
rd_a  output  WIDTH  registered read data port A
rd_b  output  WIDTH  registered read data port B
rvalid  output  1  one-cycle pulse: rd_a/rd_b updated this cycle
flat_q  output  WIDTH*DEPTH  continuous snapshot of all entries

Behaviour:
- Reset: while rst=1, asynchronously clear all entries, rd_a, rd_b and rvalid to 0. Any pending read is discarded; no rvalid pulse follows reset release.
- Write: at a rising edge with we=1, store wdata into entry waddr.
  - The write is ignored if waddr>=DEPTH.
  - The write is ignored if ZERO_REG0=1 and waddr=0.
- Read latency is 1 cycle:
  - ren=1 at edge N loads rd_a/rd_b at edge N; they are visible during cycle N+1, and rvalid=1 in that cycle.
  - ren=0 at an edge: rd_a/rd_b hold their previous value and rvalid=0.
- Read value for address x:
  - 0 if x>=DEPTH.
  - 0 if ZERO_REG0=1 and x=0.
  - Otherwise the entry contents.
- Write-first bypass: if we=1 and ren=1 at the same edge with raddr equal to a valid, writable waddr, that port returns wdata, not the old contents. Bypass applies per port, independently. It is suppressed for ignored writes (out-of-range address, or entry 0 when hardwired).
- Both ports may read the same address in the same cycle; both return identical data.
- Back-to-back reads: ren held high gives a new rd_a/rd_b every cycle and rvalid stays 1.
- flat_q is combinational from storage:
  - Entry i occupies bits [(DEPTH-i)*WIDTH-1 : (DEPTH-i-1)*WIDTH], so entry 0 is in the MSBs.
  - With ZERO_REG0=1, the entry 0 field is always 0.
  - flat_q reflects a write from the cycle after its edge; no bypass.
- Width rules:
  - Addresses are compared as unsigned SEL_W-bit values.
  - There is no arithmetic on data.
  - DEPTH<2**SEL_W is legal; the unused codes take the out-of-range rule.
- Compile-time check: DEPTH>2**SEL_W or DEPTH<2 is an elaboration error.

Decomposition:
- Shared package holds:
  - default WIDTH/DEPTH/SEL_W constants;
  - localparam for the zero-entry index (0);
  - a function computing a field's base bit index in flat_q, reused by existing flat-bus selectors.
- One natural sub-module: multiplex_sel. It is a combinational, parametrised WIDTH x DEPTH selector from a flat bus plus address, with zero default on out-of-range. It is instantiated twice, once per read port, with bypass and registering in the parent.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> rd_a=rd_b=0, rvalid=0, flat_q=0 immediately, without waiting for a clock edge.
- Write/readback: write 0xDEADBEEF to 3 and 0x12345678 to 15; ren with raddr_a=3, raddr_b=15 -> next cycle rd_a=0xDEADBEEF, rd_b=0x12345678, rvalid=1 for exactly one cycle.
- Bypass: entry 5=0x11111111; same edge we=1, waddr=5, wdata=0x22222222, ren=1, raddr_a=5, raddr_b=5 -> both ports 0x22222222; flat_q field 5 = 0x22222222 afterwards.
- Zero entry: write 0xFFFFFFFF to 0 with ZERO_REG0=1 -> read of 0 returns 0 and flat_q[511:480]=0. With ZERO_REG0=0 the same sequence returns 0xFFFFFFFF.
- Out-of-range: DEPTH=16, write 0xAAAAAAAA to address 20 -> no entry changes; read of address 20 returns 0 with rvalid=1.
- Reset mid-read: ren=1 at edge N, rst asserted before edge N+1 -> rvalid=0 and rd_a=0. After release with ren=0, rvalid stays 0.
